// File: rtl/com_send.sv
// com_send: responder side of the console send handshake.
//
// On a send request the block latches the bag type, RAM start address and
// payload length. It reads the payload from the shared packet RAM one byte at
// a time and streams a framed byte sequence to the downstream byte link:
//
//   HEAD0  HEAD1  {0,btype}  {0,dlen[11:8]}  dlen[7:0]  payload...  [csum]
//
// Completion is signalled on fd_com_send with a four-phase handshake.
//
// Build option:
//   COM_SEND_CHECKSUM_EN  When defined, a trailing byte is appended. It holds
//                         the 8-bit sum of TYPE, LENH, LENL and the payload
//                         bytes. When undefined, the checksum state and the
//                         accumulator are not built.
module com_send #(
  parameter logic [7:0] HEAD0 = 8'h55,
  parameter logic [7:0] HEAD1 = 8'hAA,
  parameter int         AW    = 12,
  parameter int         DLW   = 12
) (
  input  logic           clk,
  input  logic           rst,

  // console handshake and latched request fields
  input  logic           fs_com_send,
  output logic           fd_com_send,
  input  logic [3:0]     send_btype,
  input  logic [AW-1:0]  ram_addr_init,
  input  logic [DLW-1:0] ram_dlen,

  // packet RAM read port (data returns one cycle after the strobe)
  output logic           ram_rd_en,
  output logic [AW-1:0]  ram_rd_addr,
  input  logic [7:0]     ram_rd_data,

  // outgoing byte stream
  output logic [7:0]     tx_data,
  output logic           tx_valid,
  input  logic           tx_ready,

  output logic           busy
);

  // FSM encoding
  localparam logic [3:0] IDLE  = 4'd0;
  localparam logic [3:0] SYN0  = 4'd1;
  localparam logic [3:0] SYN1  = 4'd2;
  localparam logic [3:0] TYPE  = 4'd3;
  localparam logic [3:0] LENH  = 4'd4;
  localparam logic [3:0] LENL  = 4'd5;
  localparam logic [3:0] RD    = 4'd6;
  localparam logic [3:0] RWAIT = 4'd7;
  localparam logic [3:0] DATA  = 4'd8;
  localparam logic [3:0] CSUM  = 4'd9;
  localparam logic [3:0] DONE  = 4'd10;

  logic [3:0]     state_q;
  logic [3:0]     btype_q;
  logic [AW-1:0]  addr_q;
  logic [DLW-1:0] dlen_q;
  logic [DLW-1:0] remain_q;

  // A byte leaves the block on any cycle where it is both offered and taken.
  logic accept;
  assign accept = tx_valid && tx_ready;

  // Only IDLE counts as not busy.
  assign busy = (state_q != IDLE);

`ifdef COM_SEND_CHECKSUM_EN
  logic [7:0] csum_q;
  logic [7:0] csum_add;

  // Running sum including the byte currently on tx_data. It is used both to
  // update the accumulator on accept and to form the checksum byte itself.
  assign csum_add = csum_q + tx_data;

  // Checksum accumulator: cleared on request accept, and advanced on each
  // accepted TYPE, LENH, LENL and payload byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      csum_q <= 8'h00;
    end else if (state_q == IDLE && fs_com_send) begin
      csum_q <= 8'h00;
    end else if (accept && (state_q == TYPE || state_q == LENH ||
                            state_q == LENL || state_q == DATA)) begin
      csum_q <= csum_add;
    end
  end
`endif

  // Frame sequencer. All outputs are registered and loaded on the transition
  // into the state that owns them. Each byte state therefore presents a
  // stable tx_data for as long as the sink stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register here samples the pre-edge value of every other register.
      state_q     <= IDLE;
      btype_q     <= 4'h0;
      addr_q      <= '0;
      dlen_q      <= '0;
      remain_q    <= '0;
      fd_com_send <= 1'b0;
      ram_rd_en   <= 1'b0;
      ram_rd_addr <= '0;
      tx_data     <= 8'h00;
      tx_valid    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (fs_com_send) begin
            btype_q  <= send_btype;
            addr_q   <= ram_addr_init;
            dlen_q   <= ram_dlen;
            remain_q <= ram_dlen;
            tx_data  <= HEAD0;
            tx_valid <= 1'b1;
            state_q  <= SYN0;
          end
        end

        SYN0: begin
          if (accept) begin
            tx_data <= HEAD1;
            state_q <= SYN1;
          end
        end

        SYN1: begin
          if (accept) begin
            tx_data <= {4'h0, btype_q};
            state_q <= TYPE;
          end
        end

        TYPE: begin
          if (accept) begin
            tx_data <= {4'h0, dlen_q[11:8]};
            state_q <= LENH;
          end
        end

        LENH: begin
          if (accept) begin
            tx_data <= dlen_q[7:0];
            state_q <= LENL;
          end
        end

        LENL: begin
          if (accept) begin
            if (dlen_q == '0) begin
`ifdef COM_SEND_CHECKSUM_EN
              tx_data     <= csum_add;
              state_q     <= CSUM;
`else
              tx_valid    <= 1'b0;
              fd_com_send <= 1'b1;
              state_q     <= DONE;
`endif
            end else begin
              tx_valid    <= 1'b0;
              ram_rd_en   <= 1'b1;
              ram_rd_addr <= addr_q;
              state_q     <= RD;
            end
          end
        end

        // The read strobe was raised on entry; drop it after a single cycle.
        RD: begin
          ram_rd_en <= 1'b0;
          state_q   <= RWAIT;
        end

        // RAM data is valid now, one cycle after the strobe.
        RWAIT: begin
          tx_data  <= ram_rd_data;
          tx_valid <= 1'b1;
          state_q  <= DATA;
        end

        DATA: begin
          if (accept) begin
            addr_q   <= addr_q + AW'(1);
            remain_q <= remain_q - DLW'(1);
            if (remain_q == DLW'(1)) begin
`ifdef COM_SEND_CHECKSUM_EN
              tx_data     <= csum_add;
              state_q     <= CSUM;
`else
              tx_valid    <= 1'b0;
              fd_com_send <= 1'b1;
              state_q     <= DONE;
`endif
            end else begin
              tx_valid    <= 1'b0;
              ram_rd_en   <= 1'b1;
              ram_rd_addr <= addr_q + AW'(1);
              state_q     <= RD;
            end
          end
        end

`ifdef COM_SEND_CHECKSUM_EN
        CSUM: begin
          if (accept) begin
            tx_valid    <= 1'b0;
            fd_com_send <= 1'b1;
            state_q     <= DONE;
          end
        end
`endif

        // Hold done until the console withdraws its request. This guarantees
        // one frame per request even though the request is a level.
        DONE: begin
          if (!fs_com_send) begin
            fd_com_send <= 1'b0;
            state_q     <= IDLE;
          end
        end

        default: begin
          tx_valid    <= 1'b0;
          ram_rd_en   <= 1'b0;
          fd_com_send <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_com_send.sv
// tb_com_send: scoreboard bench for com_send.
// Expected frame bytes and RAM read addresses are queued when a request is
// issued. They are popped and compared as the DUT accepts bytes and strobes
// RAM reads. The bench follows COM_SEND_CHECKSUM_EN in the same way as the DUT.
module tb_com_send;

  logic        clk = 1'b0;
  logic        rst;
  logic        fs_com_send;
  logic        fd_com_send;
  logic [3:0]  send_btype;
  logic [11:0] ram_addr_init;
  logic [11:0] ram_dlen;
  logic        ram_rd_en;
  logic [11:0] ram_rd_addr;
  logic [7:0]  ram_rd_data;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy;

  com_send dut (
    .clk           (clk),
    .rst           (rst),
    .fs_com_send   (fs_com_send),
    .fd_com_send   (fd_com_send),
    .send_btype    (send_btype),
    .ram_addr_init (ram_addr_init),
    .ram_dlen      (ram_dlen),
    .ram_rd_en     (ram_rd_en),
    .ram_rd_addr   (ram_rd_addr),
    .ram_rd_data   (ram_rd_data),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Packet RAM model: one-cycle read latency.
  logic [7:0] mem [0:4095];
  always @(posedge clk) if (ram_rd_en) ram_rd_data <= mem[ram_rd_addr];

  // Scoreboard state
  logic [7:0]  exp_q[$];
  logic [11:0] rd_q[$];
  bit          mon_en     = 1'b0;
  bit          tog_mode   = 1'b0;
  bit          stall_pend = 1'b0;
  logic [7:0]  stall_data = 8'h00;
  int          pops       = 0;
  int          rd_cnt     = 0;
  logic [11:0] last_rd    = 12'h000;

  // Sink ready pattern: constantly high, or toggling every cycle.
  initial begin
    tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (tog_mode) tx_ready = ~tx_ready;
      else          tx_ready = 1'b1;
    end
  end

  // Monitor on the falling edge, midway between active edges.
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (tx_valid && tx_ready) begin
        check("byte_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) check("tx_byte", tx_data, exp_q.pop_front());
        pops++;
      end
      if (stall_pend && tx_valid) check("stall_hold", tx_data, stall_data);
      stall_pend = tx_valid && !tx_ready;
      stall_data = tx_data;
      if (ram_rd_en) begin
        rd_cnt++;
        last_rd = ram_rd_addr;
        check("read_expected", rd_q.size() != 0, 1);
        if (rd_q.size() != 0) check("rd_addr", ram_rd_addr, rd_q.pop_front());
      end
    end
  end

  // Queue the bytes and reads one frame should produce.
  task automatic build_expected(input logic [3:0] bt, input logic [11:0] a, input logic [11:0] n);
    logic [7:0]  s;
    logic [11:0] ad;
    exp_q.delete();
    rd_q.delete();
    exp_q.push_back(8'h55);
    exp_q.push_back(8'hAA);
    exp_q.push_back({4'h0, bt});
    exp_q.push_back({4'h0, n[11:8]});
    exp_q.push_back(n[7:0]);
    s = {4'h0, bt} + {4'h0, n[11:8]} + n[7:0];
    for (int i = 0; i < int'(n); i++) begin
      ad = a + 12'(i);
      exp_q.push_back(mem[ad]);
      rd_q.push_back(ad);
      s = s + mem[ad];
    end
`ifdef COM_SEND_CHECKSUM_EN
    exp_q.push_back(s);
`endif
    pops       = 0;
    rd_cnt     = 0;
    stall_pend = 1'b0;
  endtask

  // Wait for done, then release the request and check the handshake.
  task automatic finish_frame(input logic [11:0] n);
    int c = 0;
    while (!fd_com_send && c < 5000) begin
      @(negedge clk);
      c++;
    end
    check("fd_rise", fd_com_send, 1);
    check("bytes_left", exp_q.size(), 0);
    check("rd_count", rd_cnt, int'(n));
    @(posedge clk);
    #1 fs_com_send = 1'b0;
    @(negedge clk);
    check("fd_hold", fd_com_send, 1);
    @(negedge clk);
    check("fd_fall", fd_com_send, 0);
    check("busy_idle", busy, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input logic [3:0] bt, input logic [11:0] a, input logic [11:0] n, input bit tog);
    build_expected(bt, a, n);
    tog_mode      = tog;
    send_btype    = bt;
    ram_addr_init = a;
    ram_dlen      = n;
    fs_com_send   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    // Inputs may wander during the frame; the latched fields must not.
    send_btype    = 4'(~bt);
    ram_addr_init = 12'($urandom);
    ram_dlen      = 12'($urandom);
    finish_frame(n);
    tog_mode = 1'b0;
  endtask

  initial begin
    int c;
    for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
    mem[12'hFCC] = 8'h12;
    mem[12'hFCD] = 8'h34;
    rst           = 1'b1;
    fs_com_send   = 1'b0;
    send_btype    = 4'h0;
    ram_addr_init = 12'h000;
    ram_dlen      = 12'h000;
    repeat (3) @(posedge clk);
    #1;
    check("rst_fd", fd_com_send, 0);
    check("rst_rd_en", ram_rd_en, 0);
    check("rst_rd_addr", ram_rd_addr, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_busy", busy, 0);
    rst    = 1'b0;
    mon_en = 1'b1;
    @(posedge clk);
    #1;

    run_frame(4'h8, 12'hFCC, 12'd2, 1'b0);   // 55 AA 08 00 02 12 34 [50]
    run_frame(4'h8, 12'hFCC, 12'd2, 1'b1);   // same under backpressure
    run_frame(4'h9, 12'h123, 12'd0, 1'b0);   // zero length, no reads
    run_frame(4'h3, 12'hFFF, 12'd3, 1'b0);   // address wrap
    run_frame(4'hD, 12'h240, 12'h202, 1'b0); // long frame
    check("long_last_rd", last_rd, 12'h441);
    run_frame(4'h5, 12'h7F0, 12'd5, 1'b1);

    // Reset after three payload bytes with the request held high.
    build_expected(4'h5, 12'h100, 12'd10);
    send_btype    = 4'h5;
    ram_addr_init = 12'h100;
    ram_dlen      = 12'd10;
    fs_com_send   = 1'b1;
    c = 0;
    while (pops < 8 && c < 1000) begin
      @(negedge clk);
      c++;
    end
    check("pre_reset_bytes", pops, 8);
    @(posedge clk);
    #1 rst = 1'b1;
    mon_en = 1'b0;
    @(posedge clk);
    #1;
    check("mid_rst_fd", fd_com_send, 0);
    check("mid_rst_rd_en", ram_rd_en, 0);
    check("mid_rst_rd_addr", ram_rd_addr, 0);
    check("mid_rst_tx_data", tx_data, 0);
    check("mid_rst_tx_valid", tx_valid, 0);
    check("mid_rst_busy", busy, 0);
    build_expected(4'h6, 12'h300, 12'd4);
    send_btype    = 4'h6;
    ram_addr_init = 12'h300;
    ram_dlen      = 12'd4;
    mon_en        = 1'b1;
    rst           = 1'b0;
    finish_frame(12'd4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
